// File: rtl/sid_dac_frame_tx.sv
// Serialises two 12-bit SID samples into parallel 16-bit MCP4922-style SPI frames (shared clk/csb/ldac).
// Optional build macro SID_DAC_DUAL_CHANNEL_EN adds a complemented channel-B frame to every sequence.
module sid_dac_frame_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter bit          GAIN_1X = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample_in_1,
    input  logic [11:0] sample_in_2,
    input  logic        sample_ready,
    input  logic        buffered,
    output logic        spi_clk,
    output logic        spi_csb,
    output logic        spi_dat_1,
    output logic        spi_dat_2,
    output logic        spi_leb,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  dbg_state_o
);

    // Handshake: sample_ready is a level request sampled only in IDLE; while busy is high
    // requests are dropped (never queued), and frame_done pulses once per accepted request.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_CSHI  = 3'd4,
        S_LATCH = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic        last_q;
    logic [15:0] sr1_q;
    logic [15:0] sr2_q;
    logic        phase_end;
    logic [15:0] frame1_d;
    logic [15:0] frame2_d;

    assign phase_end   = (div_q == DIV_LAST);
    assign frame1_d    = {1'b0, buffered, GAIN_1X, 1'b1, sample_in_1};
    assign frame2_d    = {1'b0, buffered, GAIN_1X, 1'b1, sample_in_2};
    assign dbg_state_o = state_q;

`ifdef SID_DAC_DUAL_CHANNEL_EN
    logic [15:0] frame1b_d;
    logic [15:0] frame2b_d;
    logic [15:0] hold1_q;
    logic [15:0] hold2_q;
    logic        second_q;

    // Channel B carries the complement so the two DAC outputs form a differential pair.
    assign frame1b_d = {1'b1, buffered, GAIN_1X, 1'b1, ~sample_in_1};
    assign frame2b_d = {1'b1, buffered, GAIN_1X, 1'b1, ~sample_in_2};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= 8'd0;
            bit_q      <= 4'd0;
            last_q     <= 1'b0;
            sr1_q      <= 16'd0;
            sr2_q      <= 16'd0;
            spi_clk    <= 1'b0;
            spi_csb    <= 1'b1;
            spi_leb    <= 1'b1;
            spi_dat_1  <= 1'b0;
            spi_dat_2  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SID_DAC_DUAL_CHANNEL_EN
            hold1_q    <= 16'd0;
            hold2_q    <= 16'd0;
            second_q   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (state_q != S_IDLE) begin
                div_q <= phase_end ? 8'd0 : div_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (sample_ready) begin
                        sr1_q     <= frame1_d;
                        sr2_q     <= frame2_d;
                        spi_dat_1 <= frame1_d[15];
                        spi_dat_2 <= frame2_d[15];
                        spi_csb   <= 1'b0;
                        busy      <= 1'b1;
                        bit_q     <= 4'd0;
                        last_q    <= 1'b0;
                        state_q   <= S_SETUP;
`ifdef SID_DAC_DUAL_CHANNEL_EN
                        hold1_q   <= frame1b_d;
                        hold2_q   <= frame2b_d;
                        second_q  <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        spi_clk <= 1'b1;
                        state_q <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // Falling edge: the DAC has sampled, so advance to the next bit (zeros fill in).
                    if (phase_end) begin
                        spi_clk   <= 1'b0;
                        sr1_q     <= {sr1_q[14:0], 1'b0};
                        sr2_q     <= {sr2_q[14:0], 1'b0};
                        spi_dat_1 <= sr1_q[14];
                        spi_dat_2 <= sr2_q[14];
                        bit_q     <= bit_q + 4'd1;
                        last_q    <= (bit_q == 4'd15);
                        state_q   <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        if (last_q) begin
                            spi_csb   <= 1'b1;
                            spi_dat_1 <= 1'b0;
                            spi_dat_2 <= 1'b0;
                            state_q   <= S_CSHI;
                        end else begin
                            spi_clk <= 1'b1;
                            state_q <= S_HIGH;
                        end
                    end
                end
                S_CSHI: begin
                    if (phase_end) begin
`ifdef SID_DAC_DUAL_CHANNEL_EN
                        if (!second_q) begin
                            second_q  <= 1'b1;
                            sr1_q     <= hold1_q;
                            sr2_q     <= hold2_q;
                            spi_dat_1 <= hold1_q[15];
                            spi_dat_2 <= hold2_q[15];
                            spi_csb   <= 1'b0;
                            bit_q     <= 4'd0;
                            last_q    <= 1'b0;
                            state_q   <= S_SETUP;
                        end else begin
                            spi_leb <= 1'b0;
                            state_q <= S_LATCH;
                        end
`else
                        spi_leb <= 1'b0;
                        state_q <= S_LATCH;
`endif
                    end
                end
                S_LATCH: begin
                    if (phase_end) begin
                        spi_leb    <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sid_dac_frame_tx.sv
// Directed bench for sid_dac_frame_tx: a D=2 instance and a D=1 instance share one bus monitor.
// Expectations adapt to SID_DAC_DUAL_CHANNEL_EN when it is defined.
module tb_sid_dac_frame_tx;

    localparam int D0 = 2;
    localparam int D1 = 1;
`ifdef SID_DAC_DUAL_CHANNEL_EN
    localparam int NFR = 2;
    localparam int SEQ = 69;
`else
    localparam int NFR = 1;
    localparam int SEQ = 35;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] s1 [2];
    logic [11:0] s2 [2];
    logic [1:0]  rdy, bufd;
    logic [1:0]  sclk, csb, d1, d2, leb, busy, fdone;
    logic [2:0]  dbg0, dbg1;

    sid_dac_frame_tx #(.CLK_DIV(D0), .GAIN_1X(1'b1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .sample_in_1(s1[0]), .sample_in_2(s2[0]),
        .sample_ready(rdy[0]), .buffered(bufd[0]), .spi_clk(sclk[0]), .spi_csb(csb[0]),
        .spi_dat_1(d1[0]), .spi_dat_2(d2[0]), .spi_leb(leb[0]), .busy(busy[0]),
        .frame_done(fdone[0]), .dbg_state_o(dbg0)
    );

    sid_dac_frame_tx #(.CLK_DIV(D1), .GAIN_1X(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .sample_in_1(s1[1]), .sample_in_2(s2[1]),
        .sample_ready(rdy[1]), .buffered(bufd[1]), .spi_clk(sclk[1]), .spi_csb(csb[1]),
        .spi_dat_1(d1[1]), .spi_dat_2(d2[1]), .spi_leb(leb[1]), .busy(busy[1]),
        .frame_done(fdone[1]), .dbg_state_o(dbg1)
    );

    // ---------------- bus monitor (scoreboard capture) ----------------
    logic        sel = 1'b0;
    logic        m_clk, m_csb, m_d1, m_d2, m_leb, m_busy, m_fd;
    assign m_clk  = sclk[sel];
    assign m_csb  = csb[sel];
    assign m_d1   = d1[sel];
    assign m_d2   = d2[sel];
    assign m_leb  = leb[sel];
    assign m_busy = busy[sel];
    assign m_fd   = fdone[sel];

    logic        p_clk, p_csb, p_leb, p_busy;
    logic        seen_fall = 1'b0;
    logic [15:0] sh1, sh2;
    int          rises_f, leb_cnt, low_cnt;
    int          rises_tot = 0;
    int          fd_cnt = 0;
    int unsigned start_cyc = 0;
    logic [15:0] w1_q[$];
    logic [15:0] w2_q[$];
    int          nr_q[$], leb_q[$], len_q[$], gap_q[$], fdc_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            p_clk   <= 1'b0;
            p_csb   <= 1'b1;
            p_leb   <= 1'b1;
            p_busy  <= 1'b0;
            sh1     <= 16'd0;
            sh2     <= 16'd0;
            rises_f <= 0;
            leb_cnt <= 0;
            low_cnt <= 0;
        end else begin
            p_clk  <= m_clk;
            p_csb  <= m_csb;
            p_leb  <= m_leb;
            p_busy <= m_busy;
            if (m_clk && !p_clk) begin
                sh1       <= {sh1[14:0], m_d1};
                sh2       <= {sh2[14:0], m_d2};
                rises_f   <= rises_f + 1;
                rises_tot <= rises_tot + 1;
            end
            if (m_csb && !p_csb) begin
                w1_q.push_back(sh1);
                w2_q.push_back(sh2);
                nr_q.push_back(rises_f);
                rises_f <= 0;
            end
            if (!m_leb) leb_cnt <= leb_cnt + 1;
            else if (!p_leb) begin
                leb_q.push_back(leb_cnt);
                leb_cnt <= 0;
            end
            if (m_busy && !p_busy) begin
                start_cyc <= cyc;
                if (seen_fall) gap_q.push_back(low_cnt);
            end
            if (!m_busy) low_cnt <= p_busy ? 1 : low_cnt + 1;
            if (!m_busy && p_busy) seen_fall <= 1'b1;
            if (m_fd) begin
                fd_cnt <= fd_cnt + 1;
                len_q.push_back(int'(cyc - start_cyc));
                fdc_q.push_back(int'(cyc));
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pop_w1();
        return (w1_q.size() > 0) ? w1_q.pop_front() : 16'hDEAD;
    endfunction
    function automatic logic [15:0] pop_w2();
        return (w2_q.size() > 0) ? w2_q.pop_front() : 16'hDEAD;
    endfunction
    function automatic int pop_nr();
        return (nr_q.size() > 0) ? nr_q.pop_front() : -1;
    endfunction
    function automatic int pop_leb();
        return (leb_q.size() > 0) ? leb_q.pop_front() : -1;
    endfunction
    function automatic int pop_len();
        return (len_q.size() > 0) ? len_q.pop_front() : -1;
    endfunction
    function automatic int pop_gap();
        return (gap_q.size() > 0) ? gap_q.pop_front() : -1;
    endfunction
    function automatic int pop_fdc();
        return (fdc_q.size() > 0) ? fdc_q.pop_front() : -1;
    endfunction

    task automatic clr_q();
        w1_q.delete(); w2_q.delete(); nr_q.delete(); leb_q.delete();
        len_q.delete(); gap_q.delete(); fdc_q.delete();
    endtask

    task automatic chk_frames(input string tag, input logic [15:0] a1, input logic [15:0] a2,
                              input logic [15:0] b1, input logic [15:0] b2);
        chk({tag, "_dac1_a"}, 32'(pop_w1()), 32'(a1));
        chk({tag, "_dac2_a"}, 32'(pop_w2()), 32'(a2));
        chk({tag, "_rises_a"}, 32'(pop_nr()), 32'd16);
`ifdef SID_DAC_DUAL_CHANNEL_EN
        chk({tag, "_dac1_b"}, 32'(pop_w1()), 32'(b1));
        chk({tag, "_dac2_b"}, 32'(pop_w2()), 32'(b2));
        chk({tag, "_rises_b"}, 32'(pop_nr()), 32'd16);
`else
        if (b1 === 16'hDEAD && b2 === 16'hDEAD) $display("note: unexpected channel-B marker");
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse(input int i);
        @(negedge clk);
        rdy[i] = 1'b1;
        @(negedge clk);
        rdy[i] = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target, input int budget);
        int k = 0;
        while (fd_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(fd_cnt), 32'(target));
    endtask

    task automatic wait_rises(input string tag, input int target, input int budget);
        int k = 0;
        while (rises_f < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rises_f), 32'(target));
    endtask

    // ---------------- directed sequence ----------------
    int base;
    int base_rises;
    int t_prev;
    int t_now;

    initial begin
        rst_n = 1'b0;
        rdy   = 2'b00;
        bufd  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s1[i] = 12'h000;
            s2[i] = 12'h000;
        end
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({sclk[0], csb[0], leb[0], d1[0], d2[0], busy[0], fdone[0]}), 32'b0110000);
        chk("rst_state", 32'(dbg0), 32'd0);
        rst_n = 1'b1;

        // Single frame, D=2, buffered=1
        clr_q();
        bufd[0] = 1'b1; s1[0] = 12'hA5C; s2[0] = 12'h3F0;
        base = fd_cnt;
        pulse(0);
        wait_fd("a5c_done", base + 1, 400);
        chk_frames("a5c", 16'h7A5C, 16'h73F0, 16'hF5A3, 16'hFC0F);
        chk("a5c_len", 32'(pop_len()), 32'(SEQ * D0));
        chk("a5c_leb_w", 32'(pop_leb()), 32'(D0));
        chk("a5c_leb_n", 32'(leb_q.size()), 32'd0);
        chk("a5c_idle", 32'({busy[0], csb[0], leb[0], sclk[0]}), 32'b0110);

        // Inputs changed mid-frame must not disturb the frame in flight
        clr_q();
        bufd[0] = 1'b1; s1[0] = 12'h123; s2[0] = 12'h0AA;
        base = fd_cnt;
        pulse(0);
        wait_rises("chg_bit4", 4, 400);
        s1[0] = 12'h456; bufd[0] = 1'b0;
        wait_fd("chg_done1", base + 1, 400);
        pulse(0);
        wait_fd("chg_done2", base + 2, 400);
        chk_frames("chg1", 16'h7123, 16'h70AA, 16'hFEDC, 16'hFF55);
        chk_frames("chg2", 16'h3456, 16'h30AA, 16'hBBA9, 16'hBF55);

        // Requests while busy are dropped, not queued
        clr_q();
        bufd[0] = 1'b0; s1[0] = 12'h001; s2[0] = 12'h800;
        base = fd_cnt;
        pulse(0);
        repeat (10) @(negedge clk);
        pulse(0);
        repeat (20) @(negedge clk);
        pulse(0);
        wait_fd("drop_done", base + 1, 400);
        repeat (200) @(negedge clk);
        chk("drop_fd_cnt", 32'(fd_cnt), 32'(base + 1));
        chk("drop_words", 32'(w1_q.size()), 32'(NFR));
        chk_frames("drop", 16'h3001, 16'h3800, 16'hBFFE, 16'hB7FF);

        // Reset at bit 7 aborts the frame cleanly
        clr_q();
        bufd[0] = 1'b1; s1[0] = 12'hFFF; s2[0] = 12'h000;
        base = fd_cnt;
        pulse(0);
        wait_rises("mid_bit7", 7, 400);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_outs", 32'({sclk[0], csb[0], leb[0], busy[0], fdone[0]}), 32'b01100);
        chk("mid_rst_state", 32'(dbg0), 32'd0);
        base_rises = rises_tot;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_no_clk", 32'(rises_tot), 32'(base_rises));
        chk("mid_no_fd", 32'(fd_cnt), 32'(base));
        chk("mid_no_word", 32'(w1_q.size()), 32'd0);
        s1[0] = 12'h5A5; s2[0] = 12'h1E1;
        pulse(0);
        wait_fd("mid_after", base + 1, 400);
        chk_frames("mid_after", 16'h75A5, 16'h71E1, 16'hFA5A, 16'hFE1E);

        // Back-to-back frames on the D=1 instance with sample_ready held high
        sel = 1'b1;
        repeat (2) @(negedge clk);
        clr_q();
        bufd[1] = 1'b0; s1[1] = 12'hFFF; s2[1] = 12'h000;
        base = fd_cnt;
        @(negedge clk);
        rdy[1] = 1'b1;
        wait_fd("b2b_three", base + 3, 600);
        rdy[1] = 1'b0;
        wait_fd("b2b_four", base + 4, 300);
        for (int f = 0; f < 4; f++) begin
            chk_frames($sformatf("b2b%0d", f), 16'h3FFF, 16'h3000, 16'hB000, 16'hBFFF);
        end
        chk("b2b_len", 32'(pop_len()), 32'(SEQ * D1));
        chk("b2b_leb_w", 32'(pop_leb()), 32'(D1));
        t_prev = pop_fdc();
        for (int f = 0; f < 3; f++) begin
            t_now = pop_fdc();
            chk($sformatf("b2b_period%0d", f), 32'(t_now - t_prev), 32'(SEQ * D1 + 1));
            t_prev = t_now;
        end
        void'(pop_gap());
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("b2b_gap%0d", f), 32'(pop_gap()), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sid_dac_frame_tx.md
Name: sid_dac_frame_tx

Overview:
- Downstream stage of the SID core. Takes the two 12-bit mixed/filtered sample words and serialises them in parallel to two external MCP4922-style SPI DACs, one per SID instance.
- Sends one 16-bit frame per DAC on separate data lines, with a shared clock, chip-select and latch strobe.
- Runs continuously from the system clock. A new frame starts whenever the block is idle and sample_ready is high.

Parameters:
- CLK_DIV, 2, number of clk cycles per spi_clk half-period; legal range 1..255.
- GAIN_1X, 1, value driven into frame bit 13 (GAb); 1 = 1x gain.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sample_in_1  in  12  sample for DAC 1
- sample_in_2  in  12  sample for DAC 2
- sample_ready  in  1  start request; sampled only while idle
- buffered  in  1  value driven into frame bit 14 (BUF)
- spi_clk  out  1  serial clock, idles low
- spi_csb  out  1  chip select, active low
- spi_dat_1  out  1  serial data to DAC 1
- spi_dat_2  out  1  serial data to DAC 2
- spi_leb  out  1  LDAC latch strobe, active low
- busy  out  1  high while a frame sequence is in progress
- frame_done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset values (rst_n=0 at clk edge), all applied on the next edge, including mid-frame:
  - spi_clk=0, spi_csb=1, spi_leb=1, spi_dat_1=0, spi_dat_2=0, busy=0, frame_done=0.
  - State returns to IDLE; divider and bit counter cleared.
- Frame word per DAC, MSB first: {1'b0 (channel A), buffered, GAIN_1X, 1'b1 (SHDNb), sample[11:0]}.
  - `buffered` is captured at frame start together with the samples.
- D = CLK_DIV. All outputs are registered.
- FSM states and transitions:
  - IDLE: outputs at idle values. If sample_ready=1, then on this edge:
    - capture both shift registers;
    - drive spi_csb=0, busy=1;
    - drive spi_dat_x = bit 15;
    - go to SETUP.
  - SETUP: hold D cycles with spi_clk=0, then drive spi_clk=1 and go to HIGH.
  - HIGH: hold D cycles with spi_clk=1, then drive spi_clk=0 and go to LOW. The DAC samples on this rising edge.
  - LOW: hold D cycles. At the falling edge, shift both registers and present the next bit.
    - If bits remain: drive spi_clk=1 and go to HIGH.
    - After the 16th bit's low phase: drive spi_csb=1 and go to CSHI.
  - CSHI: hold D cycles with spi_csb=1, then drive spi_leb=0 and go to LATCH.
  - LATCH: hold D cycles with spi_leb=0, then drive spi_leb=1, busy=0, frame_done=1 for 1 cycle, and go to IDLE.
- Exactly 16 rising spi_clk edges per frame.
- Sequence length from the start edge to frame_done is 35*D cycles (70 for D=2).
- With sample_ready held high, back-to-back frames begin 1 cycle after frame_done.
- sample_ready outside IDLE is ignored and not queued. Input changes during a frame do not affect the frame in flight.
- Both data lines change only at spi_clk falling edges or at the IDLE->SETUP edge. spi_dat_x returns to 0 in CSHI.
- Bit counter: 4-bit plus terminal flag. Divider width is 8 bits; it wraps to 0 at each phase change.

Optional Feature:
- Macro: SID_DAC_DUAL_CHANNEL_EN.
- Defined:
  - Each sequence sends two frames under separate csb assertions.
  - Frame A as above, then CSHI for D cycles.
  - Frame B with bit15=1 and data = ~sample[11:0] (differential complement), captured at sequence start.
  - Then CSHI, then LATCH. LDAC updates both channels together.
  - Sequence length is 69*D cycles.
- Undefined: channel A only, as specified above.

Test Plan:
- Reset mid-frame: assert rst_n=0 at bit 7 -> next edge spi_csb=1, spi_clk=0, spi_leb=1, busy=0. No further spi_clk edges until sample_ready is seen after reset release.
- D=2, buffered=1, sample_in_1=12'hA5C, sample_in_2=12'h3F0, sample_ready pulse -> DAC1 captures 16'h7A5C and DAC2 captures 16'h73F0 on 16 rising edges. frame_done arrives 70 cycles after the start edge, and spi_leb is low for exactly 2 cycles after csb rises.
- D=1, sample_ready held 1, samples 12'hFFF/12'h000 -> consecutive frames 16'h3FFF/16'h3000 (buffered=0). Period is 36 cycles; busy is low for exactly 1 cycle between frames.
- Change sample_in_1 from 12'h123 to 12'h456 at bit 4 of a frame -> frame carries 12'h123; next frame carries 12'h456.
- Pulse sample_ready while busy -> no extra frame, no queued frame; frame_done count equals accepted starts.
- SID_DAC_DUAL_CHANNEL_EN defined, sample_in_1=12'h100 -> frames 16'h3100 then 16'hBEFF. Two csb low windows, one spi_leb pulse after the second, frame_done 138 cycles after start for D=2.
